mod_dds_seq: RTL

- Command sequencer for the modulated-DDS datapath.
- Accepts pulse commands (parameter-memory address, sample count, phase-sync flag) over a valid/ready handshake.
- Drives the parameter-memory read address, waits out the memory read latency, then emits the time base (t, t_valid) and the DDS phase-sync strobe.
- Sits between the command FIFO/tProc side and the mod_dds + parameter BRAM pair.

---
 rtl/mod_dds_seq_pkg.sv | 34 +++
 rtl/mod_dds_seq_if.sv | 23 ++
 rtl/mod_dds_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mod_dds_seq_pkg.sv
// Shared types and constants for the modulated-DDS command sequencer.
// Repeat feature (MOD_DDS_SEQ_REPEAT_EN) is selected in mod_dds_seq.sv.
package mod_dds_seq_pkg;

   localparam int AW_DEF      = 10;
   localparam int BT_DEF      = 8;
   localparam int RW_DEF      = 8;
   localparam int MEM_LAT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   typedef struct packed {
      logic [AW_DEF-1:0] addr;
      logic [BT_DEF-1:0] len;
      logic              sync;
      logic [RW_DEF-1:0] rep;
   } cmd_t;

   // FETCH lasts MEM_LAT cycles, so the wait counter starts one below it.
   function automatic logic [3:0] lat_init(input int lat);
      logic [3:0] v;
      if (lat == 0) begin
         v = 4'd0;
      end else begin
         v = 4'(lat - 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/mod_dds_seq_if.sv
// Command handshake bundle between the command FIFO/tProc side and the sequencer.
interface mod_dds_seq_if #(
   parameter int AW = 10,
   parameter int BT = 8,
   parameter int RW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [BT-1:0] cmd_len;
   logic          cmd_sync;
   logic [RW-1:0] cmd_rep;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, cmd_sync, cmd_rep,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, cmd_sync, cmd_rep,
      output cmd_ready
   );
endinterface

// File: rtl/mod_dds_seq.sv
// Pulse command sequencer: addresses the parameter BRAM, waits its read latency,
// then emits the time base. Define MOD_DDS_SEQ_REPEAT_EN to enable cmd_rep repeats.
module mod_dds_seq
   import mod_dds_seq_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int BT      = BT_DEF,
   parameter int RW      = RW_DEF,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   mod_dds_seq_if.slave  cmd,
   input  logic          i_stop,
   output logic [AW-1:0] o_mem_addr,
   output logic [BT-1:0] o_t_out,
   output logic          o_t_valid,
   output logic          o_sync_out,
   output logic          o_busy,
   output logic          o_done
);

   localparam logic [3:0] WAIT_INIT = lat_init(MEM_LAT);
   localparam bit         NO_FETCH  = (MEM_LAT == 0);

   state_t        r_state;
   logic [3:0]    r_wait;
   logic [BT-1:0] r_len;
   logic          r_sync;
   logic [AW-1:0] r_mem_addr;
   logic [BT-1:0] r_t_out;
   logic          r_t_valid;
   logic          r_sync_out;
   logic          r_busy;
   logic          r_done;
   cmd_t          w_cmd;
   logic          w_accept;

`ifdef MOD_DDS_SEQ_REPEAT_EN
   logic [RW-1:0] r_rep;
`else
   logic [RW-1:0] w_unused_rep;
   assign w_unused_rep = w_cmd.rep;
`endif

   assign w_cmd = '{addr: cmd.cmd_addr, len: cmd.cmd_len, sync: cmd.cmd_sync, rep: cmd.cmd_rep};

   // Ready depends only on state and stop so the source never sees a combinational loop.
   assign cmd.cmd_ready = (r_state == ST_IDLE) & ~i_stop;
   assign w_accept      = cmd.cmd_valid & cmd.cmd_ready;

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_wait     <= 4'd0;
         r_len      <= {BT{1'b0}};
         r_sync     <= 1'b0;
         r_mem_addr <= {AW{1'b0}};
         r_t_out    <= {BT{1'b0}};
         r_t_valid  <= 1'b0;
         r_sync_out <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef MOD_DDS_SEQ_REPEAT_EN
         r_rep      <= {RW{1'b0}};
`endif
      end else begin
         r_done <= 1'b0;
         if (i_stop) begin
            r_state    <= ST_IDLE;
            r_t_valid  <= 1'b0;
            r_sync_out <= 1'b0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_len      <= w_cmd.len;
                     r_sync     <= w_cmd.sync;
                     r_mem_addr <= w_cmd.addr;
                     r_busy     <= 1'b1;
`ifdef MOD_DDS_SEQ_REPEAT_EN
                     r_rep      <= w_cmd.rep;
`endif
                     if (NO_FETCH) begin
                        r_state    <= ST_RUN;
                        r_t_valid  <= 1'b1;
                        r_t_out    <= {BT{1'b0}};
                        r_sync_out <= w_cmd.sync;
                     end else begin
                        r_state <= ST_FETCH;
                        r_wait  <= WAIT_INIT;
                     end
                  end
               end
               ST_FETCH: begin
                  if (r_wait == 4'd0) begin
                     r_state    <= ST_RUN;
                     r_t_valid  <= 1'b1;
                     r_t_out    <= {BT{1'b0}};
                     r_sync_out <= r_sync;
                  end else begin
                     r_wait <= r_wait - 4'd1;
                  end
               end
               ST_RUN: begin
                  r_sync_out <= 1'b0;
                  if (r_t_out == r_len) begin
`ifdef MOD_DDS_SEQ_REPEAT_EN
                     if (r_rep != {RW{1'b0}}) begin
                        r_rep   <= r_rep - RW'(1'b1);
                        r_t_out <= {BT{1'b0}};
                     end else
`endif
                     begin
                        r_state   <= ST_IDLE;
                        r_t_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                     end
                  end else begin
                     r_t_out <= r_t_out + BT'(1'b1);
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_t_valid  <= 1'b0;
                  r_sync_out <= 1'b0;
                  r_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_mem_addr = r_mem_addr;
   assign o_t_out    = r_t_out;
   assign o_t_valid  = r_t_valid;
   assign o_sync_out = r_sync_out;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

endmodule
